// File: rtl/booth_host_sequencer.sv
// Drives a serial Booth multiplier: send X, send Y, then collect the high and low product halves.
// Latency: start 1 cycle after the op handshake, prod_valid 2 cycles after mul_done; one op at a time, product held until prod_ready.
module booth_host_sequencer #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [5:0]  op_x,
    input  logic [5:0]  op_y,
    output logic        prod_valid,
    input  logic        prod_ready,
    output logic [11:0] prod,
    output logic        err,
    output logic        busy,
    output logic        mul_start,
    output logic [5:0]  mul_in,
    input  logic        mul_done,
    input  logic [5:0]  mul_out
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_X,
        SEND_Y,
        WAIT,
        GET_LO,
        HOLD
    } stateT;

    localparam logic [7:0] timeoutLast = 8'(TIMEOUT - 1);

    stateT       state;
    stateT       stateNxt;
    logic [5:0]  xLat;
    logic [5:0]  yLat;
    logic [11:0] prodReg;
    logic [7:0]  wdCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            xLat    <= 6'h00;
            yLat    <= 6'h00;
            prodReg <= 12'h000;
            wdCnt   <= 8'h00;
        end else begin
            state <= stateNxt;
            if (state == IDLE && op_valid) begin
                xLat <= op_x;
                yLat <= op_y;
            end
            if (state == SEND_Y) begin
                wdCnt <= 8'h00;
            end else if (state == WAIT && !mul_done) begin
                wdCnt <= wdCnt + 8'h01;
            end
            // Product bits pass through untouched; the multiplier owns the arithmetic.
            if (state == WAIT && mul_done) begin
                prodReg[11:6] <= mul_out;
            end
            if (state == GET_LO) begin
                prodReg[5:0] <= mul_out;
            end
        end
    end

    always_comb begin
        stateNxt   = state;
        op_ready   = 1'b0;
        mul_start  = 1'b0;
        mul_in     = 6'h00;
        prod_valid = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    stateNxt = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                stateNxt  = SEND_X;
            end
            SEND_X: begin
                mul_in   = xLat;
                stateNxt = SEND_Y;
            end
            SEND_Y: begin
                mul_in   = yLat;
                stateNxt = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    stateNxt = GET_LO;
                end else if (wdCnt == timeoutLast) begin
                    // A reset landing on the abort cycle wins, so no error escapes it.
                    err      = ~rst;
                    stateNxt = IDLE;
                end
            end
            GET_LO: begin
                stateNxt = HOLD;
            end
            HOLD: begin
                prod_valid = 1'b1;
                if (prod_ready) begin
                    stateNxt = IDLE;
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign prod = prodReg;

endmodule

// File: tb/tb_booth_host_sequencer.sv
// Directed bench for booth_host_sequencer with a behavioural serial multiplier attached.
module tb_booth_host_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  op_x;
    logic [5:0]  op_y;
    logic        prod_valid;
    logic        prod_ready;
    logic [11:0] prod;
    logic        err;
    logic        busy;
    logic        mul_start;
    logic [5:0]  mul_in;
    logic        mul_done;
    logic [5:0]  mul_out;

    booth_host_sequencer #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_y(op_y),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
        .err(err), .busy(busy),
        .mul_start(mul_start), .mul_in(mul_in), .mul_done(mul_done), .mul_out(mul_out)
    );

    always #5 clk = ~clk;

    // Multiplier model: start, X, Y, then done (high half) after mdlLat cycles, low half next.
    int                 mdlLat = 0;
    logic               mdlNever = 1'b0;
    logic               spurDone = 1'b0;
    logic [2:0]         ph;
    int                 mCnt;
    logic [5:0]         mX;
    logic [5:0]         mY;
    logic signed [11:0] mdlP;
    logic               mdlDone;

    always @(posedge clk) begin
        if (rst) begin
            ph   <= 3'd0;
            mCnt <= 0;
            mX   <= 6'h00;
            mY   <= 6'h00;
        end else begin
            case (ph)
                3'd0: if (mul_start) ph <= 3'd1;
                3'd1: begin mX <= mul_in; ph <= 3'd2; end
                3'd2: begin mY <= mul_in; mCnt <= mdlLat; ph <= 3'd3; end
                3'd3: begin
                    if (mul_start) ph <= 3'd1;
                    else if (mCnt == 0 && !mdlNever) ph <= 3'd4;
                    else if (mCnt != 0) mCnt <= mCnt - 1;
                end
                default: ph <= 3'd0;
            endcase
        end
    end

    assign mdlP    = $signed(mX) * $signed(mY);
    assign mdlDone = (ph == 3'd3) && (mCnt == 0) && !mdlNever;
    assign mul_done = mdlDone | spurDone;
    assign mul_out  = spurDone ? 6'h2A :
                      (ph == 3'd3) ? mdlP[11:6] :
                      (ph == 3'd4) ? mdlP[5:0] : 6'h00;

    int errCnt = 0;
    always @(negedge clk) if (err === 1'b1) errCnt++;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input logic [5:0] x, input logic [5:0] y,
                         input int lat, input int hold, input logic [11:0] exp);
        int n;
        int bad;
        mdlLat = lat;
        tick();
        op_x = x; op_y = y; op_valid = 1'b1;
        @(negedge clk);
        chk({tag, ".op_ready_c0"}, 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".mul_start_c1"}, 32'(mul_start), 32'd1);
        chk({tag, ".op_ready_c1"}, 32'(op_ready), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, ".mul_in_x_c2"}, 32'(mul_in), 32'(x));
        chk({tag, ".mul_start_c2"}, 32'(mul_start), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, ".mul_in_y_c3"}, 32'(mul_in), 32'(y));
        n = 0;
        tick();
        @(negedge clk);
        while (prod_valid !== 1'b1 && n < 40) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat + 2));
        chk({tag, ".prod"}, 32'(prod), 32'(exp));
        if (hold > 0) begin
            bad = 0;
            repeat (hold) begin
                tick();
                @(negedge clk);
                if (prod_valid !== 1'b1 || prod !== exp) bad++;
            end
            chk({tag, ".hold_stable"}, 32'(bad), 32'd0);
        end
        tick();
        prod_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".prod_valid_hs"}, 32'(prod_valid), 32'd1);
        tick();
        prod_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".op_ready_after"}, 32'(op_ready), 32'd1);
        chk({tag, ".prod_valid_after"}, 32'(prod_valid), 32'd0);
        chk({tag, ".prod_retained"}, 32'(prod), 32'(exp));
    endtask

    typedef struct {
        logic [5:0]  x;
        logic [5:0]  y;
        int          lat;
        int          hold;
        logic [11:0] exp;
    } vecT;

    vecT vecs[8];

    initial begin
        int n;
        int bad;
        vecs[0] = '{x: 6'h05, y: 6'h03, lat: 0, hold: 0,  exp: 12'h00F};
        vecs[1] = '{x: 6'h3D, y: 6'h07, lat: 2, hold: 0,  exp: 12'hFEB};
        vecs[2] = '{x: 6'h20, y: 6'h20, lat: 1, hold: 10, exp: 12'h400};
        vecs[3] = '{x: 6'h1F, y: 6'h1F, lat: 7, hold: 1,  exp: 12'h3C1};
        vecs[4] = '{x: 6'h3F, y: 6'h01, lat: 0, hold: 2,  exp: 12'hFFF};
        vecs[5] = '{x: 6'h00, y: 6'h3B, lat: 4, hold: 0,  exp: 12'h000};
        vecs[6] = '{x: 6'h20, y: 6'h1F, lat: 5, hold: 0,  exp: 12'hC20};
        vecs[7] = '{x: 6'h04, y: 6'h05, lat: 3, hold: 0,  exp: 12'h014};

        rst = 1'b1; op_valid = 1'b0; op_x = 6'h00; op_y = 6'h00; prod_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst.op_ready", 32'(op_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.prod", 32'(prod), 32'h000);
        chk("rst.prod_valid", 32'(prod_valid), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.mul_start", 32'(mul_start), 32'd0);
        chk("rst.mul_in", 32'(mul_in), 32'd0);

        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].lat, vecs[i].hold, vecs[i].exp);
        end

        // Spurious mul_done in IDLE, then in SEND_X.
        tick();
        spurDone = 1'b1;
        @(negedge clk);
        tick();
        spurDone = 1'b0;
        @(negedge clk);
        chk("spur_idle.busy", 32'(busy), 32'd0);
        chk("spur_idle.prod", 32'(prod), 32'h014);
        mdlLat = 0;
        tick();
        op_x = 6'h06; op_y = 6'h02; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        spurDone = 1'b1;
        @(negedge clk);
        chk("spur_sx.mul_in_x", 32'(mul_in), 32'h06);
        tick();
        spurDone = 1'b0;
        @(negedge clk);
        chk("spur_sx.mul_in_y", 32'(mul_in), 32'h02);
        n = 0;
        while (prod_valid !== 1'b1 && n < 40) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("spur_sx.latency", 32'(n), 32'd3);
        chk("spur_sx.prod", 32'(prod), 32'h00C);
        tick();
        prod_ready = 1'b1;
        tick();
        prod_ready = 1'b0;
        @(negedge clk);
        chk("spur_sx.op_ready", 32'(op_ready), 32'd1);
        chk("no_err_yet", 32'(errCnt), 32'd0);

        // Watchdog: multiplier never answers; abort in the 8th WAIT cycle (cycle 11).
        mdlNever = 1'b1;
        tick();
        op_x = 6'h09; op_y = 6'h09; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        bad = 0;
        repeat (7) begin
            tick();
            @(negedge clk);
            if (err !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("wd.quiet_c4_c10", 32'(bad), 32'd0);
        tick();
        @(negedge clk);
        chk("wd.err_c11", 32'(err), 32'd1);
        chk("wd.prod_valid_c11", 32'(prod_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("wd.err_c12", 32'(err), 32'd0);
        chk("wd.op_ready_c12", 32'(op_ready), 32'd1);
        chk("wd.busy_c12", 32'(busy), 32'd0);
        chk("wd.prod_unchanged", 32'(prod), 32'h00C);
        chk("wd.err_count", 32'(errCnt), 32'd1);
        mdlNever = 1'b0;

        // Reset during SEND_Y abandons the op; a fresh 2x2 then completes.
        mdlLat = 1;
        tick();
        op_x = 6'h03; op_y = 6'h03; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sy.in_send_y", 32'(mul_in), 32'h03);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sy.op_ready", 32'(op_ready), 32'd1);
        chk("rst_sy.busy", 32'(busy), 32'd0);
        chk("rst_sy.prod_valid", 32'(prod_valid), 32'd0);
        chk("rst_sy.err", 32'(err), 32'd0);
        chk("rst_sy.mul_start", 32'(mul_start), 32'd0);
        chk("rst_sy.mul_in", 32'(mul_in), 32'd0);
        chk("rst_sy.prod", 32'(prod), 32'h000);
        bad = 0;
        repeat (5) begin
            tick();
            @(negedge clk);
            if (prod_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("rst_sy.quiet", 32'(bad), 32'd0);
        runOp("after_rst", 6'h02, 6'h02, 1, 0, 12'h004);

        // Reset wins over an op handshake in the same cycle.
        tick();
        op_x = 6'h01; op_y = 6'h01; op_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        chk("rst_prio.busy", 32'(busy), 32'd0);
        chk("rst_prio.op_ready", 32'(op_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("rst_prio.no_start", 32'(mul_start), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
